// File: rtl/alu_iter.sv
// alu_iter: iterative ALU with single-bit-per-cycle shifter/rotator.
// Valid/ready on both sides; one op in flight at a time.
module alu_iter #(
  parameter int WIDTH = 8,
  parameter int SH_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [1:0]       ext,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  typedef enum logic [2:0] {
    CPY = 3'd0,
    ADD = 3'd1,
    SUB = 3'd2,
    AND = 3'd3,
    OR  = 3'd4,
    XOR = 3'd5,
    GT  = 3'd6,
    EXT = 3'd7
  } e_alu_op;

  typedef enum logic [1:0] {
    SHFL = 2'd0,
    SHFR = 2'd1,
    ROTR = 2'd2,
    ROTL = 2'd3
  } e_alu_ext_op;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } e_state;

  e_state      state_q;
  e_state      state_d;
  e_alu_op     op_e;
  e_alu_ext_op ext_q;

  logic [WIDTH-1:0] d_q;
  logic             c_q;
  logic [SH_W-1:0]  cnt_q;
  logic [SH_W-1:0]  amt;
  logic             accept;
  logic             is_shift;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  assign op_e     = e_alu_op'(op);
  assign amt      = b[SH_W-1:0];
  assign accept   = in_valid && in_ready && !flush;
  assign is_shift = (op_e == EXT) && (amt != '0);

  // Single-cycle ops; EXT by zero passes a through.
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (op_e)
      CPY: alu_r = b;
      ADD: {alu_c, alu_r} = {1'b0, a} + {1'b0, b};
      SUB: begin
        alu_r = a - b;
        alu_c = a < b;
      end
      AND: alu_r = a & b;
      OR:  alu_r = a | b;
      XOR: alu_r = a ^ b;
      GT:  alu_r = {{(WIDTH-1){1'b0}}, a > b};
      EXT: alu_r = a;
    endcase
  end

  // One shift/rotate step on the working register.
  always_comb begin
    step_r = d_q;
    step_c = 1'b0;
    unique case (ext_q)
      SHFL: begin
        step_r = {d_q[WIDTH-2:0], 1'b0};
        step_c = d_q[WIDTH-1];
      end
      SHFR: begin
        step_r = {1'b0, d_q[WIDTH-1:1]};
        step_c = d_q[0];
      end
      ROTR: begin
        step_r = {d_q[0], d_q[WIDTH-1:1]};
        step_c = d_q[0];
      end
      ROTL: begin
        step_r = {d_q[WIDTH-2:0], d_q[WIDTH-1]};
        step_c = d_q[WIDTH-1];
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush wins over everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = is_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == SH_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Working/result register, carry and step counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
      ext_q <= SHFL;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept && is_shift) begin
            d_q   <= a;
            c_q   <= 1'b0;
            cnt_q <= amt;
            ext_q <= e_alu_ext_op'(ext);
          end else if (accept) begin
            d_q   <= alu_r;
            c_q   <= alu_c;
          end
        end
        SHIFT: begin
          d_q   <= step_r;
          c_q   <= step_c;
          cnt_q <= cnt_q - SH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = d_q;
  assign zero   = (d_q == '0);
  assign carry  = c_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors against an arithmetic reference model.
// Compare process scores every cycle out_valid is high.
module tb_alu_iter;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [1:0]   ext;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;

  int checks   = 0;
  int failures = 0;

  bit          pend  = 0;
  int          exp_r = 0;
  int          exp_c = 0;

  alu_iter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .ext       (ext),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Reference: result, carry and latency straight from the op definitions.
  function automatic void model(input int o, input int x, input int av,
                                input int bv, output int r, output int c,
                                output int lat);
    int n;
    n   = bv % W;
    r   = 0;
    c   = 0;
    lat = 1;
    case (o)
      0: r = bv;
      1: begin r = (av + bv) % 256; c = (av + bv) > 255; end
      2: begin r = (av - bv + 256) % 256; c = av < bv; end
      3: r = av & bv;
      4: r = av | bv;
      5: r = av ^ bv;
      6: r = (av > bv) ? 1 : 0;
      default: begin
        lat = 1 + n;
        r   = av;
        if (n != 0) begin
          case (x)
            0: begin r = (av * (1 << n)) % 256; c = (av >> (W - n)) & 1; end
            1: begin r = av >> n; c = (av >> (n - 1)) & 1; end
            2: begin
              r = ((av >> n) | (av << (W - n))) & 255;
              c = (r >> (W - 1)) & 1;
            end
            default: begin
              r = ((av << n) | (av >> (W - n))) & 255;
              c = r & 1;
            end
          endcase
        end
      end
    endcase
  endfunction

  // Score the held result every cycle it is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!pend) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        chk("sb_result", result, exp_r);
        chk("sb_carry", carry, exp_c);
        chk("sb_zero", zero, exp_r == 0);
        chk("sb_in_ready_busy", in_ready, 0);
      end
    end
  end

  task automatic do_op(input string name, input int o, input int x,
                       input int av, input int bv, input int lit_r,
                       input int lit_c, input int hold);
    int r, c, lat, cyc;
    chk({name, "_ready"}, in_ready, 1);
    op = o[2:0]; ext = x[1:0]; a = av[7:0]; b = bv[7:0];
    in_valid = 1;
    @(posedge clk);
    model(o, x, av, bv, r, c, lat);
    exp_r = r; exp_c = c; pend = 1;
    #1;
    in_valid = 0;
    a = ~a; b = 8'($urandom); op = 3'($urandom); ext = 2'($urandom);
    cyc = 1;
    @(negedge clk);
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, cyc, lat);
    chk({name, "_lit_result"}, result, lit_r);
    chk({name, "_lit_carry"}, carry, lit_c);
    repeat (hold) @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    pend = 0;
    out_ready = 0;
    chk({name, "_idle_after"}, in_ready, 1);
    chk({name, "_valid_drop"}, out_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    op = 0; ext = 0; a = 0; b = 0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    do_op("add_ovf", 1, 0, 'hF0, 'h20, 'h10, 1, 0);
    do_op("sub_eq", 2, 0, 'h05, 'h05, 'h00, 0, 0);
    do_op("sub_brw", 2, 0, 'h03, 'h05, 'hFE, 1, 0);
    do_op("rotl3", 7, 3, 'h81, 3, 'h0C, 0, 0);
    do_op("shfr1", 7, 1, 'h81, 1, 'h40, 1, 0);
    do_op("shfl7_hold", 7, 0, 'h01, 7, 'h80, 0, 5);
    do_op("and", 3, 0, 'hCA, 'h0F, 'h0A, 0, 0);
    do_op("or", 4, 0, 'hA0, 'h05, 'hA5, 0, 1);
    do_op("xor", 5, 0, 'hFF, 'h0F, 'hF0, 0, 0);
    do_op("cpy", 0, 0, 'h12, 'h34, 'h34, 0, 0);
    do_op("gt_lt", 6, 0, 'h10, 'h20, 'h00, 0, 0);
    do_op("gt_eq", 6, 0, 'h55, 'h55, 'h00, 0, 0);
    do_op("add_wrap", 1, 0, 'hFF, 'h01, 'h00, 1, 0);
    do_op("rotr1", 7, 2, 'h01, 1, 'h80, 1, 0);
    do_op("rotr7", 7, 2, 'h01, 7, 'h02, 0, 0);
    do_op("shfl_amt0", 7, 0, 'h3C, 'h08, 'h3C, 0, 0);

    // Flush on the second shift cycle of a 7-step op.
    op = 7; ext = 0; a = 'h01; b = 7; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk);
    @(negedge clk) flush = 1;
    @(posedge clk); #1;
    chk("flush_shift_ready", in_ready, 1);
    chk("flush_shift_valid", out_valid, 0);
    flush = 0;
    repeat (10) @(negedge clk);
    chk("flush_no_valid", out_valid, 0);
    do_op("add_post_flush", 1, 0, 'h21, 'h42, 'h63, 0, 0);

    // Flush beats a request presented in IDLE.
    op = 1; a = 1; b = 1; in_valid = 1; flush = 1;
    #1 chk("flush_idle_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("flush_idle_valid", out_valid, 0);
    chk("flush_idle_state", in_ready, 1);
    in_valid = 0; flush = 0;
    @(negedge clk);

    // Flush discards a result waiting in DONE.
    op = 0; a = 0; b = 'h77; in_valid = 1;
    @(posedge clk);
    exp_r = 'h77; exp_c = 0; pend = 1;
    #1 in_valid = 0;
    @(negedge clk);
    chk("done_before_flush", out_valid, 1);
    flush = 1;
    @(posedge clk); #1;
    pend = 0; flush = 0;
    chk("flush_done_valid", out_valid, 0);
    chk("flush_done_ready", in_ready, 1);
    @(negedge clk);

    // Asynchronous reset mid-shift.
    op = 7; ext = 3; a = 'h81; b = 5; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_zero", zero, 1);
    chk("arst_carry", carry, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_op("gt_after_rst", 6, 0, 'h80, 'h7F, 'h01, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
